// File: rtl/scoreboard_register_file.sv
// Register file with two write ports, a per-register synchronous clear,
// optional write-to-read forwarding and a per-register busy scoreboard.

module scoreboard_register_file_rdport #(
    parameter int WORD_LEN   = 32,
    parameter int WORD_COUNT = 15,
    parameter int ADDR_W     = 4,
    parameter int BYPASS     = 1
) (
    input  logic [ADDR_W-1:0]                    addr_i,
    input  logic [WORD_COUNT-1:0][WORD_LEN-1:0]  regs_i,
    input  logic [WORD_COUNT-1:0]                busy_i,
    input  logic                                 sclr_i,
    input  logic [ADDR_W-1:0]                    sclr_addr_i,
    input  logic                                 wa_en_i,
    input  logic [ADDR_W-1:0]                    wa_addr_i,
    input  logic [WORD_LEN-1:0]                  wa_data_i,
    input  logic                                 wb_en_i,
    input  logic [ADDR_W-1:0]                    wb_addr_i,
    input  logic [WORD_LEN-1:0]                  wb_data_i,
    output logic [WORD_LEN-1:0]                  data_o,
    output logic                                 busy_o
);
    logic in_range;

    always_comb begin
        data_o   = '0;
        busy_o   = 1'b0;
        in_range = 1'b0;
        for (int j = 0; j < WORD_COUNT; j++) begin
            if (addr_i == ADDR_W'(j)) begin
                data_o   = regs_i[j];
                busy_o   = busy_i[j];
                in_range = 1'b1;
            end
        end
        // Forwarding follows the same sclr > A > B priority as the write itself
        if (BYPASS != 0 && in_range) begin
            if (sclr_i && sclr_addr_i == addr_i) begin
                data_o = '0;
                busy_o = 1'b0;
            end else if (wa_en_i && wa_addr_i == addr_i) begin
                data_o = wa_data_i;
                busy_o = 1'b0;
            end else if (wb_en_i && wb_addr_i == addr_i) begin
                data_o = wb_data_i;
                busy_o = 1'b0;
            end
        end
    end
endmodule

module scoreboard_register_file #(
    parameter  int WORD_LEN   = 32,
    parameter  int WORD_COUNT = 15,
    parameter  int READ_PORTS = 3,
    parameter  int BYPASS     = 1,
    localparam int ADDR_W     = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [READ_PORTS*ADDR_W-1:0]   rd_addr_i,
    output logic [READ_PORTS*WORD_LEN-1:0] rd_data_o,
    output logic [READ_PORTS-1:0]          rd_busy_o,
    input  logic                           wa_en_i,
    input  logic [ADDR_W-1:0]              wa_addr_i,
    input  logic [WORD_LEN-1:0]            wa_data_i,
    input  logic                           wb_en_i,
    input  logic [ADDR_W-1:0]              wb_addr_i,
    input  logic [WORD_LEN-1:0]            wb_data_i,
    input  logic                           sclr_i,
    input  logic [ADDR_W-1:0]              sclr_addr_i,
    input  logic                           issue_en_i,
    input  logic [ADDR_W-1:0]              issue_addr_i,
    output logic [WORD_COUNT-1:0]          busy_vec_o
);
    logic [WORD_COUNT-1:0][WORD_LEN-1:0] regs_q, regs_d;
    logic [WORD_COUNT-1:0]               busy_q, busy_d;
    logic [WORD_COUNT-1:0]               sclr_hit, wa_hit, wb_hit, set_hit;

    // Out-of-range addresses never match any index, so they fall out naturally
    for (genvar i = 0; i < WORD_COUNT; i++) begin : g_reg
        assign sclr_hit[i] = sclr_i     && (sclr_addr_i  == ADDR_W'(i));
        assign wa_hit[i]   = wa_en_i    && (wa_addr_i    == ADDR_W'(i));
        assign wb_hit[i]   = wb_en_i    && (wb_addr_i    == ADDR_W'(i));
        assign set_hit[i]  = issue_en_i && (issue_addr_i == ADDR_W'(i));

        always_comb begin
            regs_d[i] = regs_q[i];
            if (sclr_hit[i])    regs_d[i] = '0;
            else if (wa_hit[i]) regs_d[i] = wa_data_i;
            else if (wb_hit[i]) regs_d[i] = wb_data_i;
        end

        // A new issue outranks a completing write so the latest producer stays pending
        always_comb begin
            busy_d[i] = busy_q[i];
            if (set_hit[i])                                busy_d[i] = 1'b1;
            else if (sclr_hit[i] || wa_hit[i] || wb_hit[i]) busy_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WORD_COUNT; i++) regs_q[i] <= WORD_LEN'(i);
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec_o = busy_q;

    // Writes are ignored while reset is held, so reads show the reset contents at once
    logic byp_sclr, byp_wa, byp_wb;
    assign byp_sclr = sclr_i  & ~rst;
    assign byp_wa   = wa_en_i & ~rst;
    assign byp_wb   = wb_en_i & ~rst;

    for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
        scoreboard_register_file_rdport #(
            .WORD_LEN   (WORD_LEN),
            .WORD_COUNT (WORD_COUNT),
            .ADDR_W     (ADDR_W),
            .BYPASS     (BYPASS)
        ) u_rdport (
            .addr_i      (rd_addr_i[k*ADDR_W +: ADDR_W]),
            .regs_i      (regs_q),
            .busy_i      (busy_q),
            .sclr_i      (byp_sclr),
            .sclr_addr_i (sclr_addr_i),
            .wa_en_i     (byp_wa),
            .wa_addr_i   (wa_addr_i),
            .wa_data_i   (wa_data_i),
            .wb_en_i     (byp_wb),
            .wb_addr_i   (wb_addr_i),
            .wb_data_i   (wb_data_i),
            .data_o      (rd_data_o[k*WORD_LEN +: WORD_LEN]),
            .busy_o      (rd_busy_o[k])
        );
    end
endmodule

// File: tb/tb_scoreboard_register_file.sv
// Directed checks of the scoreboard register file: a table of single-cycle
// vectors on the forwarding build plus hand sequences for reset and no-forwarding.

module tb_scoreboard_register_file;
    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] rd_addr;
    logic [95:0] rd_data, rd_data0;
    logic [2:0]  rd_busy, rd_busy0;
    logic        wa_en, wb_en, sclr, issue_en;
    logic [3:0]  wa_addr, wb_addr, sclr_addr, issue_addr;
    logic [31:0] wa_data, wb_data;
    logic [14:0] busy_vec, busy_vec0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    scoreboard_register_file #(.WORD_LEN(32), .WORD_COUNT(15), .READ_PORTS(3), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
        .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
        .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .sclr_i(sclr), .sclr_addr_i(sclr_addr), .issue_en_i(issue_en), .issue_addr_i(issue_addr),
        .busy_vec_o(busy_vec)
    );

    scoreboard_register_file #(.WORD_LEN(32), .WORD_COUNT(15), .READ_PORTS(3), .BYPASS(0)) dut0 (
        .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data0), .rd_busy_o(rd_busy0),
        .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
        .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .sclr_i(sclr), .sclr_addr_i(sclr_addr), .issue_en_i(issue_en), .issue_addr_i(issue_addr),
        .busy_vec_o(busy_vec0)
    );

    typedef struct {
        logic        wa_en;  logic [3:0] wa_addr; logic [31:0] wa_data;
        logic        wb_en;  logic [3:0] wb_addr; logic [31:0] wb_data;
        logic        sc;     logic [3:0] sca;
        logic        is;     logic [3:0] isa;
        logic [11:0] ra;     // {port2, port1, port0}
        logic [95:0] ed;     // expected rd_data before the edge
        logic [2:0]  eb;     // expected rd_busy before the edge
        logic [14:0] ebv;    // expected busy_vec after the edge
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic wae, input logic [3:0] waa, input logic [31:0] wad,
                                input logic wbe, input logic [3:0] wba, input logic [31:0] wbd,
                                input logic sc, input logic [3:0] sca,
                                input logic is, input logic [3:0] isa,
                                input logic [11:0] ra, input logic [95:0] ed,
                                input logic [2:0] eb, input logic [14:0] ebv);
        vec_t v;
        v.wa_en = wae; v.wa_addr = waa; v.wa_data = wad;
        v.wb_en = wbe; v.wb_addr = wba; v.wb_data = wbd;
        v.sc = sc; v.sca = sca; v.is = is; v.isa = isa;
        v.ra = ra; v.ed = ed; v.eb = eb; v.ebv = ebv;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        wa_en = 0; wa_addr = 0; wa_data = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0;
        sclr = 0; sclr_addr = 0; issue_en = 0; issue_addr = 0;
    endtask

    initial begin
        tbl[0]  = mk(0,0,0, 0,0,0, 0,0, 0,0, {4'd14,4'd0,4'd7}, {32'd14,32'd0,32'd7}, 3'b000, 15'h0000);
        tbl[1]  = mk(1,5,32'hA5A5A5A5, 1,5,32'h12345678, 0,0, 0,0, {4'd5,4'd5,4'd5},
                     {32'hA5A5A5A5,32'hA5A5A5A5,32'hA5A5A5A5}, 3'b000, 15'h0000);
        tbl[2]  = mk(0,0,0, 0,0,0, 0,0, 0,0, {4'd15,4'd6,4'd5}, {32'd0,32'd6,32'hA5A5A5A5}, 3'b000, 15'h0000);
        tbl[3]  = mk(1,5,32'h1111, 1,5,32'h2222, 1,5, 0,0, {4'd5,4'd5,4'd5}, 96'd0, 3'b000, 15'h0000);
        tbl[4]  = mk(0,0,0, 0,0,0, 0,0, 1,4, {4'd4,4'd4,4'd5}, {32'd4,32'd4,32'd0}, 3'b000, 15'h0010);
        tbl[5]  = mk(0,0,0, 0,0,0, 0,0, 0,0, {4'd3,4'd4,4'd4}, {32'd3,32'd4,32'd4}, 3'b011, 15'h0010);
        tbl[6]  = mk(1,4,32'h55, 0,0,0, 0,0, 0,0, {4'd4,4'd5,4'd4}, {32'h55,32'd0,32'h55}, 3'b000, 15'h0000);
        tbl[7]  = mk(0,0,0, 0,0,0, 0,0, 1,2, {4'd2,4'd2,4'd2}, {32'd2,32'd2,32'd2}, 3'b000, 15'h0004);
        tbl[8]  = mk(0,0,0, 1,2,32'hBEEF, 0,0, 1,2, {4'd2,4'd2,4'd2},
                     {32'hBEEF,32'hBEEF,32'hBEEF}, 3'b000, 15'h0004);
        tbl[9]  = mk(0,0,0, 0,0,0, 0,0, 0,0, {4'd2,4'd15,4'd2}, {32'hBEEF,32'd0,32'hBEEF}, 3'b101, 15'h0004);
        tbl[10] = mk(1,15,32'hFFFF, 1,15,32'hEEEE, 1,15, 1,15, {4'd13,4'd14,4'd15},
                     {32'd13,32'd14,32'd0}, 3'b000, 15'h0004);
        tbl[11] = mk(0,0,0, 0,0,0, 0,0, 0,0, {4'd1,4'd0,4'd15}, {32'd1,32'd0,32'd0}, 3'b000, 15'h0004);
        tbl[12] = mk(0,0,0, 1,9,32'hDEAD, 0,0, 0,0, {4'd9,4'd2,4'd9},
                     {32'hDEAD,32'hBEEF,32'hDEAD}, 3'b010, 15'h0004);
        tbl[13] = mk(0,0,0, 0,0,0, 1,2, 0,0, {4'd2,4'd9,4'd2}, {32'd0,32'hDEAD,32'd0}, 3'b000, 15'h0000);
        tbl[14] = mk(1,1,32'h100, 1,6,32'h600, 0,0, 0,0, {4'd6,4'd1,4'd0},
                     {32'h600,32'h100,32'd0}, 3'b000, 15'h0000);
        tbl[15] = mk(0,0,0, 0,0,0, 0,0, 0,0, {4'd6,4'd1,4'd5}, {32'h600,32'h100,32'd0}, 3'b000, 15'h0000);

        // Reset state, observed with no clock edge
        rst = 1'b1; idle(); rd_addr = '0;
        #2;
        chk("reset_busy_vec", busy_vec, 15'h0);
        for (int i = 0; i < 15; i++) begin
            rd_addr = {4'd0, 4'd0, 4'(i)};
            #1;
            chk($sformatf("reset_reg%0d", i), rd_data[31:0], 32'(i));
        end
        @(negedge clk); rst = 1'b0;

        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            wa_en = tbl[t].wa_en; wa_addr = tbl[t].wa_addr; wa_data = tbl[t].wa_data;
            wb_en = tbl[t].wb_en; wb_addr = tbl[t].wb_addr; wb_data = tbl[t].wb_data;
            sclr = tbl[t].sc; sclr_addr = tbl[t].sca;
            issue_en = tbl[t].is; issue_addr = tbl[t].isa;
            rd_addr = tbl[t].ra;
            #1;
            chk($sformatf("v%0d_rd_data", t), rd_data, tbl[t].ed);
            chk($sformatf("v%0d_rd_busy", t), rd_busy, tbl[t].eb);
            @(posedge clk); #1;
            chk($sformatf("v%0d_busy_vec", t), busy_vec, tbl[t].ebv);
        end

        // Asynchronous reset mid-cycle while a write to reg3 is being driven
        @(negedge clk); idle();
        wa_en = 1; wa_addr = 3; wa_data = 32'h77; issue_en = 1; issue_addr = 3;
        @(negedge clk); idle();
        issue_en = 1; issue_addr = 7;   // reg3 busy, issue 7 this cycle
        wa_en = 1; wa_addr = 3; wa_data = 32'hFFFF; rd_addr = {4'd0, 4'd0, 4'd3};
        #1;
        chk("prerst_bypass", rd_data[31:0], 32'hFFFF);
        #1; rst = 1'b1; #1;
        chk("midrst_reg3", rd_data[31:0], 32'd3);
        chk("midrst_reg3_nobyp", rd_data0[31:0], 32'd3);
        chk("midrst_busy_vec", busy_vec, 15'h0);
        chk("midrst_rd_busy", rd_busy, 3'b000);
        @(negedge clk); idle();
        @(negedge clk); rst = 1'b0; #1;
        chk("postrst_reg3", rd_data[31:0], 32'd3);

        // Forwarding vs no forwarding on the same write
        @(negedge clk); idle();
        wb_en = 1; wb_addr = 9; wb_data = 32'hDEAD; rd_addr = {4'd0, 4'd0, 4'd9};
        #1;
        chk("byp1_same_cycle", rd_data[31:0], 32'hDEAD);
        chk("byp0_same_cycle", rd_data0[31:0], 32'd9);
        @(posedge clk); #1;
        chk("byp0_after_edge", rd_data0[31:0], 32'hDEAD);

        @(negedge clk); idle(); issue_en = 1; issue_addr = 4;
        @(negedge clk); idle();
        wa_en = 1; wa_addr = 4; wa_data = 32'h55; rd_addr = {4'd0, 4'd0, 4'd4};
        #1;
        chk("byp1_rd_busy_hit", rd_busy, 3'b000);
        chk("byp0_rd_busy_hit", rd_busy0, 3'b001);
        chk("byp0_old_data", rd_data0[31:0], 32'd4);
        @(posedge clk); #1;
        chk("byp1_busy_cleared", busy_vec, 15'h0);
        chk("byp0_busy_cleared", busy_vec0, 15'h0);
        @(negedge clk); idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/scoreboard_register_file.md
Name: scoreboard_register_file

Overview:
- Next-generation processor register file with a parameterised number of combinational read ports.
- Two independent write ports: port A for execute/ALU results, port B for memory/load writeback.
- A per-register synchronous clear, optional same-cycle write-to-read bypass, and a per-register busy scoreboard for hazard detection.
- Sits between the decode stage (reads, issue marking) and the execute/writeback stages (writes).

Parameters:
- WORD_LEN, 32, data width of each register.
- WORD_COUNT, 15, number of registers; ADDR_W = $clog2(WORD_COUNT) is derived locally and is not overridable.
- READ_PORTS, 3, number of read ports (1..8).
- BYPASS, 1, 1 = a write in the current cycle is forwarded to matching reads; 0 = reads return stored contents only.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rd_addr  in  READ_PORTS*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W].
- rd_data  out  READ_PORTS*WORD_LEN  packed read data, same packing as rd_addr.
- rd_busy  out  READ_PORTS  1 = addressed register has a pending producer and no forwarded value.
- wa_en  in  1  write port A enable.
- wa_addr  in  ADDR_W  write port A address.
- wa_data  in  WORD_LEN  write port A data.
- wb_en  in  1  write port B enable.
- wb_addr  in  ADDR_W  write port B address.
- wb_data  in  WORD_LEN  write port B data.
- sclr  in  1  synchronous clear of one register.
- sclr_addr  in  ADDR_W  register to clear.
- issue_en  in  1  mark a register busy (destination of a newly issued instruction).
- issue_addr  in  ADDR_W  register to mark.
- busy_vec  out  WORD_COUNT  registered scoreboard, bit i = register i busy.

Behaviour:
- Reset (asynchronous, any time, including mid-write):
  - reg[i] = i, zero-extended or truncated to WORD_LEN.
  - busy_vec = 0.
  - Outputs reflect the new state combinationally, with no clock required.
- Register write at the rising edge, per address, in priority order sclr > port A > port B:
  - sclr writes 0.
  - Port A and port B writes to different addresses both take effect in the same cycle.
  - Any address >= WORD_COUNT on sclr, port A, port B or issue: no effect.
- Read (combinational, zero latency), port k:
  - Address >= WORD_COUNT: rd_data = 0, rd_busy = 0.
  - BYPASS = 1: the same priority applies. If sclr hits the address, rd_data = 0. Otherwise if wa_en hits, rd_data = wa_data. Otherwise if wb_en hits, rd_data = wb_data. Otherwise rd_data = the stored value.
  - BYPASS = 0: rd_data = the stored value. A write becomes visible in the cycle after its edge.
- Scoreboard, per register i at the rising edge:
  - set = issue_en & issue_addr == i.
  - clr = a write (sclr, A or B) hits i.
  - set wins over clr, so the newest producer stays pending: busy[i] <= set ? 1 : clr ? 0 : busy[i].
  - busy_vec is the registered busy array.
- rd_busy[k]:
  - busy[rd_addr[k]] & ~hit, where hit = (BYPASS = 1 and a write hits rd_addr[k] this cycle).
  - With BYPASS = 0, rd_busy[k] = busy[rd_addr[k]].
- No handshake back-pressure. The producer guarantees one write per issue; an extra write to a non-busy register simply updates data.
- Concurrent reads: any number of read ports may address the same register; each returns an identical result.

Test Plan:
- Reset then read all registers -> reg i reads i (e.g., addr 7 -> 32'd7), busy_vec = 0; assert rst mid-cycle while wa_en=1 addr 3 data 0xFFFF -> reg3 reads 3 immediately.
- wa_en addr 5 data 0xA5A5A5A5 and wb_en addr 5 data 0x12345678 same edge -> reg5 = 0xA5A5A5A5; repeat with sclr addr 5 also set -> reg5 = 0.
- BYPASS=1, rd_addr port 0 = 9, wb_en addr 9 data 0xDEAD in the same cycle -> rd_data0 = 0xDEAD before the edge. BYPASS=0 -> old value before the edge, 0xDEAD after.
- issue_en addr 4 -> next cycle busy_vec[4]=1 and rd_busy=1 on a port reading 4. wa_en addr 4 data 0x55 -> rd_busy=0 in that cycle (BYPASS=1) and busy_vec[4]=0 after the edge.
- issue_en addr 2 and wb_en addr 2 on the same edge, with busy[2]=1 beforehand -> reg2 updated, busy_vec[2] stays 1.
- READ_PORTS=3, all ports read addr 15 (out of range with WORD_COUNT=15) -> rd_data = 0, rd_busy = 0; write to addr 15 -> no register or busy bit changes.
